// File: rtl/ball_engine.sv
// ball_engine: owns ball position/direction, bounces off walls and paddles,
// and emits hit/wall/goal pulses for the sound and score stages.
module ball_engine #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int BALL_SIZE  = 8,
  parameter int BALL_SPEED = 2,
  parameter int PADDLE_W   = 8,
  parameter int PADDLE_H   = 64,
  parameter int PADDLE_X_L = 16,
  parameter int PADDLE_X_R = 616,
  parameter int HOLD_TICKS = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       serve,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       hit,
  output logic       wall,
  output logic       goal,
  output logic       goal_side,
  output logic       playing
);

  localparam logic [10:0] S  = 11'(BALL_SPEED);
  localparam logic [10:0] BS = 11'(BALL_SIZE);
  localparam logic [10:0] HR = 11'(H_RES);
  localparam logic [10:0] VR = 11'(V_RES);
  localparam logic [10:0] PH = 11'(PADDLE_H);
  localparam logic [10:0] FL = 11'(PADDLE_X_L + PADDLE_W);
  localparam logic [10:0] FR = 11'(PADDLE_X_R - BALL_SIZE);
  localparam logic [9:0]  X0 = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  Y0 = 10'((V_RES - BALL_SIZE) / 2);
  localparam int          HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    SCORED
  } state_t;

  state_t        state, state_n;
  logic          dx_q, dy_q, dx_n, dy_n;
  logic [HW-1:0] hold_q, hold_n;
  logic [9:0]    x_n, y_n;
  logic          hit_n, wall_n, goal_n, side_n, playing_n;

  logic [10:0] x11, y11, pl11, pr11;
  logic        ov_l, ov_r;
  logic [9:0]  x_mv, y_mv;
  logic        dx_mv, dy_mv, hit_mv, wall_mv, goal_mv, side_mv;

  assign x11  = {1'b0, ball_x};
  assign y11  = {1'b0, ball_y};
  assign pl11 = {1'b0, paddle_l_y};
  assign pr11 = {1'b0, paddle_r_y};
  assign ov_l = (y11 + BS > pl11) && (y11 < pl11 + PH);
  assign ov_r = (y11 + BS > pr11) && (y11 < pr11 + PH);

  // dy: 1 = down
  always_comb begin
    y_mv    = ball_y;
    dy_mv   = dy_q;
    wall_mv = 1'b0;
    if (!dy_q) begin
      if (y11 <= S) begin
        y_mv    = '0;
        dy_mv   = 1'b1;
        wall_mv = 1'b1;
      end else begin
        y_mv = 10'(y11 - S);
      end
    end else if (y11 + BS + S >= VR) begin
      y_mv    = 10'(VR - BS);
      dy_mv   = 1'b0;
      wall_mv = 1'b1;
    end else begin
      y_mv = 10'(y11 + S);
    end
  end

  // dx: 1 = right; a ball behind a face never satisfies the hit window
  always_comb begin
    x_mv    = ball_x;
    dx_mv   = dx_q;
    hit_mv  = 1'b0;
    goal_mv = 1'b0;
    side_mv = goal_side;
    if (!dx_q) begin
      if (x11 >= FL && x11 <= FL + S && ov_l) begin
        x_mv   = 10'(FL);
        dx_mv  = 1'b1;
        hit_mv = 1'b1;
      end else if (x11 <= S) begin
        x_mv    = '0;
        dx_mv   = 1'b0;
        goal_mv = 1'b1;
        side_mv = 1'b1;
      end else begin
        x_mv = 10'(x11 - S);
      end
    end else begin
      if (x11 <= FR && x11 + S >= FR && ov_r) begin
        x_mv   = 10'(FR);
        dx_mv  = 1'b0;
        hit_mv = 1'b1;
      end else if (x11 + BS + S >= HR) begin
        x_mv    = 10'(HR - BS);
        dx_mv   = 1'b1;
        goal_mv = 1'b1;
        side_mv = 1'b0;
      end else begin
        x_mv = 10'(x11 + S);
      end
    end
  end

  always_comb begin
    state_n = state;
    x_n     = ball_x;
    y_n     = ball_y;
    dx_n    = dx_q;
    dy_n    = dy_q;
    hold_n  = hold_q;
    hit_n   = 1'b0;
    wall_n  = 1'b0;
    goal_n  = 1'b0;
    side_n  = goal_side;
    unique case (state)
      IDLE: begin
        if (serve) begin
          state_n = PLAY;
          dy_n    = ~dy_q;
        end
      end
      PLAY: begin
        if (tick) begin
          x_n    = x_mv;
          y_n    = y_mv;
          dx_n   = dx_mv;
          dy_n   = dy_mv;
          goal_n = goal_mv;
          side_n = side_mv;
          hit_n  = hit_mv & ~goal_mv;
          wall_n = wall_mv & ~goal_mv;
          if (goal_mv) state_n = SCORED;
        end
      end
      SCORED: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            hold_n  = '0;
            x_n     = X0;
            y_n     = Y0;
            state_n = IDLE;
          end else begin
            hold_n = hold_q + HW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    playing_n = (state_n == PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ball_x    <= X0;
      ball_y    <= Y0;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      hold_q    <= '0;
      hit       <= 1'b0;
      wall      <= 1'b0;
      goal      <= 1'b0;
      goal_side <= 1'b0;
      playing   <= 1'b0;
    end else begin
      state     <= state_n;
      ball_x    <= x_n;
      ball_y    <= y_n;
      dx_q      <= dx_n;
      dy_q      <= dy_n;
      hold_q    <= hold_n;
      hit       <= hit_n;
      wall      <= wall_n;
      goal      <= goal_n;
      goal_side <= side_n;
      playing   <= playing_n;
    end
  end

endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: directed trajectories with hand-computed positions
// and event pulses; a tall-screen instance reaches a paddle/wall corner.
module tb_ball_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       serve = 1'b0;
  logic       serve2 = 1'b0;
  logic [9:0] pl = 10'd280;
  logic [9:0] pr = 10'd20;
  logic [9:0] pr2 = 10'd0;

  logic [9:0] bx, by, bx2, by2;
  logic hit, wall, goal, gs, playing;
  logic hit2, wall2, goal2, gs2, playing2;

  int n_chk = 0;
  int n_fail = 0;

  ball_engine dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .serve(serve),
    .paddle_l_y(pl), .paddle_r_y(pr),
    .ball_x(bx), .ball_y(by),
    .hit(hit), .wall(wall), .goal(goal),
    .goal_side(gs), .playing(playing)
  );

  ball_engine #(.V_RES(592)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .serve(serve2),
    .paddle_l_y(10'd0), .paddle_r_y(pr2),
    .ball_x(bx2), .ball_y(by2),
    .hit(hit2), .wall(wall2), .goal(goal2),
    .goal_side(gs2), .playing(playing2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int x, input int y);
    chk({tag, ".x"}, 32'(bx), x);
    chk({tag, ".y"}, 32'(by), y);
  endtask

  task automatic chk_ev(input string tag, input int h, input int w,
                        input int g);
    chk({tag, ".hit"}, 32'(hit), h);
    chk({tag, ".wall"}, 32'(wall), w);
    chk({tag, ".goal"}, 32'(goal), g);
  endtask

  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic pulse_serve();
    @(negedge clk) serve = 1'b1;
    @(negedge clk) serve = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_pos("reset", 316, 236);
    chk_ev("reset", 0, 0, 0);
    chk("reset.side", 32'(gs), 0);
    chk("reset.playing", 32'(playing), 0);
    chk("reset2.y", 32'(by2), 292);

    ticks(3);
    chk_pos("idle_ticks", 316, 236);
    chk("idle_ticks.playing", 32'(playing), 0);

    // tall screen: top wall and right face reached on the same tick
    @(negedge clk) serve2 = 1'b1;
    @(negedge clk) serve2 = 1'b0;
    chk("corner.playing", 32'(playing2), 1);
    ticks(145);
    chk("corner_pre.x", 32'(bx2), 606);
    chk("corner_pre.y", 32'(by2), 2);
    chk_pos("idle_long", 316, 236);
    do_tick();
    chk("corner.x", 32'(bx2), 608);
    chk("corner.y", 32'(by2), 0);
    chk("corner.hit", 32'(hit2), 1);
    chk("corner.wall", 32'(wall2), 1);
    chk("corner.goal", 32'(goal2), 0);
    @(negedge clk);
    chk("corner_end.hit", 32'(hit2), 0);
    chk("corner_end.wall", 32'(wall2), 0);
    do_tick();
    chk("corner_next.x", 32'(bx2), 606);
    chk("corner_next.y", 32'(by2), 2);

    // serve coinciding with tick: no motion yet
    @(negedge clk) begin serve = 1'b1; tick = 1'b1; end
    @(negedge clk) begin serve = 1'b0; tick = 1'b0; end
    chk("serve_tick.playing", 32'(playing), 1);
    chk_pos("serve_tick", 316, 236);
    do_tick();
    chk_pos("first_move", 318, 234);
    chk_ev("first_move", 0, 0, 0);

    ticks(115);
    chk_pos("t116", 548, 4);
    do_tick();
    chk_pos("t117", 550, 2);
    chk_ev("t117", 0, 0, 0);
    do_tick();
    chk_pos("top_wall", 552, 0);
    chk_ev("top_wall", 0, 1, 0);
    @(negedge clk);
    chk("top_wall_end.wall", 32'(wall), 0);
    do_tick();
    chk_pos("after_wall", 554, 2);

    ticks(26);
    chk_pos("t145", 606, 54);
    do_tick();
    chk_pos("right_hit", 608, 56);
    chk_ev("right_hit", 1, 0, 0);
    @(negedge clk);
    chk("right_hit_end.hit", 32'(hit), 0);
    do_tick();
    chk_pos("after_rhit", 606, 58);

    ticks(290);
    chk_pos("t437", 26, 306);
    do_tick();
    chk_pos("left_hit", 24, 304);
    chk_ev("left_hit", 1, 0, 0);
    @(negedge clk);
    chk("left_hit_end.hit", 32'(hit), 0);
    do_tick();
    chk_pos("after_lhit", 26, 302);
    chk("after_lhit.playing", 32'(playing), 1);

    // asynchronous reset in flight
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk_pos("rst_flight", 316, 236);
    chk("rst_flight.playing", 32'(playing), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk_ev("rst_flight_rel", 0, 0, 0);

    // same path, left paddle out of reach
    pl = 10'd0;
    pulse_serve();
    chk("serve2.playing", 32'(playing), 1);
    ticks(437);
    chk_pos("miss_pre", 26, 306);
    do_tick();
    chk_pos("miss", 24, 304);
    chk_ev("miss", 0, 0, 0);
    ticks(11);
    chk_pos("goal_pre", 2, 282);
    do_tick();
    chk_pos("goal", 0, 280);
    chk_ev("goal", 0, 0, 1);
    chk("goal.side", 32'(gs), 1);
    chk("goal.playing", 32'(playing), 0);
    @(negedge clk);
    chk("goal_end.goal", 32'(goal), 0);
    chk("goal_end.side", 32'(gs), 1);
    ticks(59);
    chk_pos("hold59", 0, 280);
    chk("hold59.playing", 32'(playing), 0);
    do_tick();
    chk_pos("recentre", 316, 236);
    chk("recentre.playing", 32'(playing), 0);
    pulse_serve();
    chk("reserve.playing", 32'(playing), 1);
    do_tick();
    chk_pos("reserve_move", 314, 238);

    ticks(116);
    chk_pos("r3_t117", 82, 470);
    do_tick();
    chk_pos("bot_wall", 80, 472);
    chk_ev("bot_wall", 0, 1, 0);
    ticks(39);
    chk_pos("r3_goal_pre", 2, 394);
    do_tick();
    chk_pos("r3_goal", 0, 392);
    chk_ev("r3_goal", 0, 0, 1);
    chk("r3_goal.side", 32'(gs), 1);

    // asynchronous reset during the goal pulse, in SCORED
    rst_n = 1'b0;
    #1;
    chk("rst_pulse.goal", 32'(goal), 0);
    chk("rst_pulse.side", 32'(gs), 0);
    chk_pos("rst_pulse", 316, 236);
    chk("rst_pulse.playing", 32'(playing), 0);
    @(negedge clk) rst_n = 1'b1;
    do_tick();
    chk_ev("rst_pulse_rel", 0, 0, 0);
    chk_pos("rst_pulse_rel", 316, 236);
    chk("rst_pulse_rel.playing", 32'(playing), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Upstream stage of the sound/scoring path: owns ball position and direction, advances the ball once per frame tick, and bounces it off the top/bottom walls and the two paddles.
- Emits single-cycle hit, wall and goal event pulses. The sound stage consumes these directly; the score logic consumes goal and goal_side.
- Also drives ball_x/ball_y to the pixel renderer.

Parameters:
- H_RES, 640, active pixels per line.
- V_RES, 480, active lines.
- BALL_SIZE, 8, ball edge length in pixels.
- BALL_SPEED, 2, pixels moved per axis per tick.
- PADDLE_W, 8, paddle width.
- PADDLE_H, 64, paddle height.
- PADDLE_X_L, 16, left paddle left edge.
- PADDLE_X_R, 616, right paddle left edge.
- HOLD_TICKS, 60, ticks spent in SCORED before re-centring.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle pulse per frame; sole motion timebase
- serve  in  1  one-cycle pulse; launches the ball from IDLE
- paddle_l_y  in  10  left paddle top y (already clamped to screen)
- paddle_r_y  in  10  right paddle top y
- ball_x  out  10  ball left x
- ball_y  out  10  ball top y
- hit  out  1  one-cycle pulse: paddle bounce
- wall  out  1  one-cycle pulse: top/bottom bounce
- goal  out  1  one-cycle pulse: ball passed a paddle
- goal_side  out  1  side that scored (1 = right player, ball left via left edge); held until next goal
- playing  out  1  high in PLAY state

Behaviour:
- **Reset (async, rst_n low):**
  - state IDLE; ball_x = (H_RES-BALL_SIZE)/2 = 316; ball_y = (V_RES-BALL_SIZE)/2 = 236.
  - dx = right, dy = down; hit/wall/goal/goal_side/playing = 0; hold counter = 0.
  - Reset mid-play aborts immediately to these values.
- **Outputs:** all outputs registered. Event pulses are exactly 1 clk wide, asserted in the cycle after the tick that caused them. Inputs are sampled on the tick cycle.
- **IDLE:**
  - Ball held at centre; ticks ignored.
  - serve -> PLAY next cycle, with dx = current dx (towards the side that conceded last; right after reset).
  - dy toggles on every serve.
  - serve together with tick: enter PLAY; motion starts on the following tick.
  - serve outside IDLE is ignored.
- **PLAY, each tick** (S = BALL_SPEED, F_L = PADDLE_X_L+PADDLE_W = 24, F_R = PADDLE_X_R-BALL_SIZE = 608).
  - **Vertical:**
    - Moving up and y <= S: y = 0, dy = down, wall.
    - Moving down and y+BALL_SIZE+S >= V_RES: y = V_RES-BALL_SIZE, dy = up, wall.
    - Else y ± S.
  - **Horizontal left:**
    - Moving left and x >= F_L and x-S <= F_L and vertical overlap (ball_y+BALL_SIZE > paddle_l_y and ball_y < paddle_l_y+PADDLE_H, using pre-move y): x = F_L, dx = right, hit.
    - Else moving left and x <= S: x = 0, goal, goal_side = 1, dx set to left for next serve, state SCORED.
  - **Horizontal right:** mirror of left.
    - Hit when x <= F_R and x+S >= F_R with overlap against paddle_r_y.
    - Goal when x+BALL_SIZE+S >= H_RES: x = H_RES-BALL_SIZE, goal_side = 0, dx = right.
  - **Otherwise:** x ± S.
  - A ball already behind a paddle face (x < F_L or x > F_R) cannot register a hit.
- **Simultaneous events:**
  - hit and wall in the same tick both pulse.
  - goal suppresses wall and hit in that tick; y still updates.
- **SCORED:**
  - Ball frozen; hold counter increments on each tick.
  - When the counter reaches HOLD_TICKS-1 on a tick: counter = 0, ball re-centred, state IDLE.
- **Arithmetic:** all comparisons on 11-bit unsigned intermediates; no wrap or underflow permitted.

Test Plan:
- Reset -> ball_x=316, ball_y=236, all pulses 0, playing=0; ticks without serve leave ball unchanged; serve -> playing=1 next cycle, dy=up (toggled), next tick ball_x=318, ball_y=234.
- Ball y=3 moving up, x mid-screen: tick -> y=1, no wall; tick -> y=0, wall pulse 1 cycle, next tick y=2.
- Ball x=26 moving left, y=230, paddle_l_y=200: tick -> x=24, hit 1 cycle, dx right; next tick x=26.
- Same with paddle_l_y=300: ball passes; on tick with x=2 -> x=0, goal=1 for 1 cycle, goal_side=1; after 60 ticks ball at (316,236), IDLE; next serve moves ball left.
- Corner case: x=26 moving left, y=1 moving up, paddle_l_y=0: single tick -> hit and wall in same cycle, x=24, y=0.
- rst_n low mid-flight, in SCORED and during a pulse cycle -> outputs return to reset values asynchronously, no pulse after release.
